// File: rtl/fir_sym_pipe.sv
// -----------------------------------------------------------------------------
// fir_sym_pipe
//   Parametrised symmetric (linear-phase) FIR filter with runtime-loadable
//   coefficients. The datapath has three registered stages after the delay
//   line: pre-add of mirrored taps, signed multiply, then full-precision sum
//   with arithmetic right shift and optional saturation.
//
// Ports
//   clk        in   clock
//   rstN       in   asynchronous active-low reset
//   in_valid   in   sample strobe; in_data accepted on every edge where high
//   in_data    in   signed input sample [DATA_W]
//   flush      in   synchronous clear of delay line, pipeline and counter
//   coef_wr    in   coefficient write strobe
//   coef_addr  in   unique-coefficient index, 0..M-1 with M = (TAPS+1)/2
//   coef_data  in   signed coefficient value [COEF_W]
//   coef_err   out  one-cycle pulse: coefficient write was rejected
//   out_valid  out  one-cycle pulse: out_data carries a new result
//   out_data   out  filtered sample [OUT_W], held between pulses
//   primed     out  high once TAPS samples were accepted since reset/flush
// -----------------------------------------------------------------------------
module fir_sym_pipe #(
  parameter  int DATA_W = 16,
  parameter  int COEF_W = 16,
  parameter  int TAPS   = 9,
  parameter  int OUT_W  = 16,
  parameter  int SHIFT  = 0,
  parameter  int SAT    = 1,
  localparam int M      = (TAPS + 1) / 2,
  localparam int A_W    = $clog2(M)
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  input  logic                     coef_wr,
  input  logic        [A_W-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     primed
);

  localparam int P_W   = DATA_W + 1;           // pre-add width
  localparam int MUL_W = P_W + COEF_W;         // product width
  localparam int S_W   = MUL_W + $clog2(M);    // full-precision sum width
  localparam int C_W   = $clog2(TAPS + 1);     // sample counter width

  // Clamp limits expressed at sum width (assumes S_W >= OUT_W).
  localparam logic signed [S_W-1:0] MAX_V = {{(S_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] MIN_V = ~MAX_V;

  logic signed [DATA_W-1:0] r_dly  [TAPS];
  logic signed [COEF_W-1:0] r_coef [M];
  logic signed [P_W-1:0]    w_pre  [M];
  logic signed [P_W-1:0]    r_pre  [M];
  logic signed [MUL_W-1:0]  r_mul  [M];
  logic signed [S_W-1:0]    w_sum;
  logic signed [S_W-1:0]    w_scaled;
  logic signed [OUT_W-1:0]  w_out;

  logic                     r_v0;       // delay line holds a freshly accepted sample
  logic                     r_v1;       // r_pre valid
  logic                     r_v2;       // r_mul valid
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_coef_err;
  logic [C_W-1:0]           r_cnt;

  logic                     w_busy;
  logic                     w_addr_ok;
  logic                     w_coef_ok;

  // Coefficients may only change while nothing is in flight, so every result
  // is computed from one consistent coefficient set.
  assign w_busy    = in_valid | r_v0 | r_v1 | r_v2;
  assign w_addr_ok = {1'b0, coef_addr} < (A_W+1)'(M);
  assign w_coef_ok = coef_wr & ~w_busy & w_addr_ok;

  // ---------------------------------------------------------------------------
  // Delay line: d[0] is the newest sample, history starts zero-filled.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the shift register into a single stage.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < TAPS; i++) r_dly[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < TAPS; i++) r_dly[i] <= '0;
    end else if (in_valid) begin
      r_dly[0] <= in_data;
      for (int i = 1; i < TAPS; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient store
  // ---------------------------------------------------------------------------
  // NOTE: the coefficient array is explicitly reset because a filter that
  // comes out of reset must produce zeros, not whatever the flops powered up as.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < M; k++) r_coef[k] <= '0;
    end else if (w_coef_ok) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: fold mirrored taps; the centre tap has no partner.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any conditional
  // or loop assignment so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_pre = '{default: '0};
    for (int k = 0; k < M - 1; k++) begin
      w_pre[k] = P_W'(r_dly[k]) + P_W'(r_dly[TAPS-1-k]);
    end
    w_pre[M-1] = P_W'(r_dly[M-1]);
  end

  // Datapath registers carry no reset: they are only observed through the
  // valid chain, which is reset.
  always_ff @(posedge clk) begin
    if (r_v0) begin
      for (int k = 0; k < M; k++) r_pre[k] <= w_pre[k];
    end
  end

  // Stage 2: signed multiply at full product width.
  always_ff @(posedge clk) begin
    if (r_v1) begin
      for (int k = 0; k < M; k++) r_mul[k] <= MUL_W'(r_pre[k]) * MUL_W'(r_coef[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: full-precision sum, arithmetic shift, saturate or wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < M; k++) w_sum = w_sum + S_W'(r_mul[k]);
    w_scaled = w_sum >>> SHIFT;
    w_out    = w_scaled[OUT_W-1:0];
    if (SAT != 0) begin
      if (w_scaled > MAX_V)      w_out = MAX_V[OUT_W-1:0];
      else if (w_scaled < MIN_V) w_out = MIN_V[OUT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Valid chain, output register, write-reject pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_coef_err  <= 1'b0;
    end else begin
      r_coef_err <= coef_wr & ~w_coef_ok;
      if (flush) begin
        // out_data is deliberately left untouched by flush.
        r_v0        <= 1'b0;
        r_v1        <= 1'b0;
        r_v2        <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_v0        <= in_valid;
        r_v1        <= r_v0;
        r_v2        <= r_v1;
        r_out_valid <= r_v2;
        if (r_v2) r_out_data <= w_out;
      end
    end
  end

  // Accepted-sample counter, saturating at TAPS.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (in_valid && (r_cnt != C_W'(TAPS))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign coef_err  = r_coef_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign primed    = (r_cnt == C_W'(TAPS));

endmodule

// File: tb/tb_fir_sym_pipe.sv
// -----------------------------------------------------------------------------
// tb_fir_sym_pipe
//   Drives three filter instances with identical stimulus:
//     [0] SHIFT=0 SAT=1, [1] SHIFT=0 SAT=0 (wrap), [2] SHIFT=4 SAT=1.
//   Stimulus pushes hand-computed expected results (with their expected
//   output cycle) into a scoreboard; an independent monitor pops and compares
//   whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_fir_sym_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstN;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               flush;
  logic               coef_wr;
  logic        [2:0]  coef_addr;
  logic signed [15:0] coef_data;

  logic               err [3];
  logic               ov  [3];
  logic signed [15:0] od  [3];
  logic               pr  [3];

  fir_sym_pipe #(.SHIFT(0), .SAT(1)) u_dut (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(err[0]), .out_valid(ov[0]), .out_data(od[0]), .primed(pr[0]));

  fir_sym_pipe #(.SHIFT(0), .SAT(0)) u_wrap (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(err[1]), .out_valid(ov[1]), .out_data(od[1]), .primed(pr[1]));

  fir_sym_pipe #(.SHIFT(4), .SAT(1)) u_shift (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(err[2]), .out_valid(ov[2]), .out_data(od[2]), .primed(pr[2]));

  typedef struct {
    int at;   // cycle count at which out_valid must be seen
    int v0;   // expected out_data, instance 0
    int v1;   // instance 1
    int v2;   // instance 2
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Impulse response for coef = 2,0,6,18,32 and the same divided by 16 (floor).
  int H [9] = '{2, 0, 6, 18, 32, 18, 6, 0, 2};
  int HS[9] = '{0, 0, 0, 1, 2, 1, 0, 0, 0};
  int Z [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ov[0] || ov[1] || ov[2]) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid @cycle %0d: got out_valid=%0b%0b%0b, required none",
                 cyc, ov[0], ov[1], ov[2]);
      end else begin
        m_e = sb.pop_front();
        check("out_cycle", cyc, m_e.at);
        check("out_valid_sat", ov[0], 1);
        check("out_valid_wrap", ov[1], 1);
        check("out_valid_shift", ov[2], 1);
        check("out_data_sat", od[0], m_e.v0);
        check("out_data_wrap", od[1], m_e.v1);
        check("out_data_shift", od[2], m_e.v2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    coef_wr  = 1'b0;
    flush    = 1'b0;
    repeat (n) step();
  endtask

  // Present one sample; optionally record its expected result 3 edges after
  // the accepting edge.
  task automatic send(input int x, input bit exp_en, input int e0, input int e1, input int e2);
    exp_t e;
    in_valid = 1'b1;
    in_data  = x[15:0];
    if (exp_en) begin
      e.at = cyc + 4;
      e.v0 = e0;
      e.v1 = e1;
      e.v2 = e2;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wcoef(input int addr, input int data, input bit exp_err);
    coef_wr   = 1'b1;
    coef_addr = addr[2:0];
    coef_data = data[15:0];
    step();
    coef_wr = 1'b0;
    check($sformatf("coef_err_addr%0d", addr), err[0], exp_err);
  endtask

  // Unit impulse followed by 8 zeros, one sample every `gap` cycles.
  task automatic impulse(input int em[9], input int es[9], input int gap, input bit chk_primed);
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 1 : 0, 1'b1, em[i], em[i], es[i]);
      if (chk_primed && i >= 7) check($sformatf("primed_after_%0d", i + 1), pr[0], (i == 8));
      if (gap > 1) idle(gap - 1);
    end
  endtask

  // Sample x followed by 4 zeros; x reaches the centre tap on the 5th result.
  task automatic pulse5(input int x, input int e0, input int e1, input int e2);
    send(x, 1'b1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(0, 1'b1, 0, 0, 0);
    send(0, 1'b1, e0, e1, e2);
  endtask

  initial begin
    rstN      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    coef_wr   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out_valid[%0d]", i), ov[i], 0);
      check($sformatf("reset_out_data[%0d]", i), od[i], 0);
      check($sformatf("reset_coef_err[%0d]", i), err[i], 0);
      check($sformatf("reset_primed[%0d]", i), pr[i], 0);
    end
    rstN = 1'b1;
    idle(2);

    // Load coefficients and run the continuous impulse.
    wcoef(0, 2, 1'b0);
    wcoef(1, 0, 1'b0);
    wcoef(2, 6, 1'b0);
    wcoef(3, 18, 1'b0);
    wcoef(4, 32, 1'b0);
    impulse(H, HS, 1, 1'b1);
    idle(5);

    // Writes while a sample is presented, while the pipeline drains, and out
    // of range are all rejected; the response must still use the old set.
    coef_wr   = 1'b1;
    coef_addr = 3'd4;
    coef_data = 16'sd100;
    send(1, 1'b1, H[0], H[0], HS[0]);
    coef_wr = 1'b0;
    check("coef_err_while_in_valid", err[0], 1);
    for (int i = 1; i < 9; i++) send(0, 1'b1, H[i], H[i], HS[i]);
    coef_wr   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'sd99;
    step();
    coef_wr = 1'b0;
    check("coef_err_while_busy", err[0], 1);
    idle(5);
    wcoef(5, 7, 1'b1);
    idle(2);

    // Flush two cycles after a nonzero sample: that sample must vanish.
    send(5, 1'b0, 0, 0, 0);
    idle(1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("primed_after_flush", pr[0], 0);
    check("out_data_held_on_flush", od[0], 2);
    idle(5);
    impulse(H, HS, 1, 1'b1);
    idle(5);

    // Gapped input: same values, results spaced three cycles apart.
    impulse(H, HS, 3, 1'b0);
    idle(5);

    // Centre tap only: saturation, wrap and shift behaviour.
    wcoef(0, 0, 1'b0);
    wcoef(1, 0, 1'b0);
    wcoef(2, 0, 1'b0);
    wcoef(3, 0, 1'b0);
    pulse5(2000, 32767, -1536, 4000);
    pulse5(-2000, -32768, 1536, -4000);
    pulse5(100, 3200, 3200, 200);
    pulse5(-1, -32, -32, -2);
    idle(5);

    // Reset in mid-stream: outputs clear at once, no stale results later,
    // and the coefficients come back as zero.
    send(7, 1'b0, 0, 0, 0);
    send(7, 1'b0, 0, 0, 0);
    #2;
    rstN = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset_out_data[%0d]", i), od[i], 0);
      check($sformatf("midreset_out_valid[%0d]", i), ov[i], 0);
      check($sformatf("midreset_primed[%0d]", i), pr[i], 0);
    end
    @(posedge clk);
    #1;
    rstN = 1'b1;
    idle(6);
    impulse(Z, Z, 1, 1'b1);
    idle(6);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_sym_pipe.md
Name: fir_sym_pipe

Overview:
Parametrised symmetric (linear-phase) FIR filter. It is the successor to the fixed 9-tap, 16-bit combinational-sum filter. It adds generic tap count and widths, runtime-loadable coefficients, valid handshaking, a 3-stage pipelined pre-add/multiply/sum datapath, output scaling with optional saturation, and flush. It sits in the filter datapath between the sample source and downstream consumers, and replaces hardwired filter instances.

Parameters:
DATA_W, 16, input sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 9, number of taps; must be odd and >= 3
OUT_W, 16, output width (signed)
SHIFT, 0, arithmetic right shift applied to the full-precision sum before output
SAT, 1, 1 = saturate to OUT_W range; 0 = wrap (keep low OUT_W bits)

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
in_valid  in  1  sample strobe; in_data accepted on every rising edge where high
in_data  in  DATA_W  input sample
flush  in  1  synchronous clear of delay line and pipeline
coef_wr  in  1  coefficient write strobe
coef_addr  in  clog2(M)  unique-coefficient index, M=(TAPS+1)/2
coef_data  in  COEF_W  coefficient value
coef_err  out  1  one-cycle pulse: coefficient write rejected
out_valid  out  1  one-cycle pulse: out_data is valid
out_data  out  OUT_W  filtered sample
primed  out  1  high once TAPS samples have been accepted since reset/flush

Behaviour:
- Reset (rstN low, async): delay line = 0, all coef[] = 0, pipeline valid bits = 0, out_valid = 0, out_data = 0, coef_err = 0, primed = 0, sample counter = 0.
- Delay line d[0..TAPS-1]; d[0] holds the newest sample. It shifts only on edges with in_valid=1. History is zero-filled, so output is produced from the first sample.
- Coefficient mapping: tap i uses coef[min(i, TAPS-1-i)]. coef[M-1] is the centre tap.
- Stage 1 (pre-add): p[k] = d[k] + d[TAPS-1-k] for k<M-1, and p[M-1] = d[M-1]; width DATA_W+1.
- Stage 2 (multiply): m[k] = p[k]*coef[k], signed; width DATA_W+1+COEF_W.
- Stage 3 (sum): S = sum of m[k], accumulated at full precision (DATA_W+1+COEF_W+clog2(M) bits), no internal overflow.
- Then R = S >>> SHIFT (arithmetic, truncation). If SAT=1, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; if SAT=0, take the low OUT_W bits.
- Latency: a sample accepted at edge N produces out_valid=1 after edge N+3, for exactly one cycle. out_data holds its value between pulses.
- Throughput is one sample per clock. in_valid gaps propagate as out_valid gaps.
- Coefficient write is honoured only when idle: in_valid=0 and no stage valid bit set in the same cycle. A honoured write updates coef[coef_addr] at that edge. Otherwise the write is dropped and coef_err pulses after that edge. coef_addr >= M is also dropped with coef_err.
- flush=1: at that edge, delay line = 0, stage valid bits = 0, counter = 0, primed = 0. Coefficients and out_data are retained. flush takes priority over a simultaneous in_valid (the sample is discarded). coef_wr in the same cycle as flush is honoured if the idle rule holds.
- primed: the counter saturates at TAPS. primed=1 from the edge that accepts the TAPS-th sample.
- Reset mid-stream: all in-flight results are lost, and no out_valid is produced for pre-reset samples.

Test Plan:
- TAPS=9, coef[0..4]=2,0,6,18,32, in_data 1 then 8 zeros (in_valid continuous) -> out_data 2,0,6,18,32,18,6,0,2 on consecutive out_valid pulses; first pulse 3 cycles after the impulse; primed high after the 9th sample.
- Saturation: coef[4]=32, others 0, SAT=1, in_data=2000 -> 32767; in_data=-2000 -> -32768. With SAT=0 the same input -> 64000 mod 2^16 = -1536.
- SHIFT=4, coef[4]=32, in_data=100 -> 200; in_data=-1 -> -2 (floor).
- coef_wr asserted while in_valid=1 or the pipeline is busy -> coef_err pulse and coefficient unchanged (a following impulse response matches the old set). A write to coef_addr=5 -> coef_err.
- flush asserted 2 cycles after a nonzero sample -> no out_valid for that sample, primed=0, next impulse response identical to the post-reset response.
- Gapped input (in_valid every 3rd cycle) -> identical out_data sequence to the continuous case, with out_valid spacing of 3 cycles. rstN pulsed mid-stream -> all outputs 0 immediately, no stale out_valid.
